// File: rtl/binop_seq_alu.sv
// Sequential binary-op ALU: single-cycle logic/compare/add ops, iterative shift-add MUL and restoring DIV/MOD.
// Define BINOP_SEQ_ALU_POW_EN to build the square-and-multiply POW engine (op 20); otherwise op 20 is illegal.
module binop_seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int             CW   = $clog2(WIDTH);
  localparam int             WP1  = WIDTH + 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH:0] WLIM = WP1'(WIDTH);

  localparam logic [4:0] OP_AND  = 5'd0,  OP_OR  = 5'd1,  OP_XOR  = 5'd2,  OP_XNOR = 5'd3;
  localparam logic [4:0] OP_SHL  = 5'd4,  OP_SHR = 5'd5,  OP_SSHR = 5'd6,  OP_LAND = 5'd7;
  localparam logic [4:0] OP_LOR  = 5'd8,  OP_EQ  = 5'd9,  OP_NE   = 5'd10, OP_LT   = 5'd11;
  localparam logic [4:0] OP_LE   = 5'd12, OP_GE  = 5'd13, OP_GT   = 5'd14, OP_ADD  = 5'd15;
  localparam logic [4:0] OP_SUB  = 5'd16, OP_MUL = 5'd17, OP_DIV  = 5'd18, OP_MOD  = 5'd19;
`ifdef BINOP_SEQ_ALU_POW_EN
  localparam logic [4:0] OP_POW  = 5'd20;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
`ifdef BINOP_SEQ_ALU_POW_EN
    S_POW,
`endif
    S_DONE
  } state_t;

  // Returns {err, result} for every op that completes in one cycle; anything else is illegal.
  function automatic logic [WIDTH:0] single_op(input logic [4:0] o,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0]        r;
    logic signed [WIDTH-1:0] sx;
    logic                    e;
    logic                    big;
    r   = '0;
    e   = 1'b0;
    big = ({1'b0, y} >= WLIM);
    sx  = $signed(x) >>> y;
    case (o)
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      OP_XNOR: r = ~(x ^ y);
      OP_SHL:  r = big ? '0 : (x << y);
      OP_SHR:  r = big ? '0 : (x >> y);
      OP_SSHR: r = big ? {WIDTH{x[WIDTH-1]}} : $unsigned(sx);
      OP_LAND: r = {{(WIDTH-1){1'b0}}, (x != '0) && (y != '0)};
      OP_LOR:  r = {{(WIDTH-1){1'b0}}, (x != '0) || (y != '0)};
      OP_EQ:   r = {{(WIDTH-1){1'b0}}, x == y};
      OP_NE:   r = {{(WIDTH-1){1'b0}}, x != y};
      OP_LT:   r = {{(WIDTH-1){1'b0}}, x <  y};
      OP_LE:   r = {{(WIDTH-1){1'b0}}, x <= y};
      OP_GE:   r = {{(WIDTH-1){1'b0}}, x >= y};
      OP_GT:   r = {{(WIDTH-1){1'b0}}, x >  y};
      OP_ADD:  r = x + y;
      OP_SUB:  r = x - y;
      default: e = 1'b1;
    endcase
    return {e, r};
  endfunction

  state_t           state_q, state_d;
  logic             go_q, go_d;
  logic [4:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] mc_q, mc_d, mp_q, mp_d, pp_q, pp_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] pp_nx;
  logic [WIDTH:0]   rem_sh, trial;
  logic [WIDTH-1:0] rem_nx, quo_nx;
  logic [WIDTH:0]   res1;
  logic             last;

  assign pp_nx  = pp_q + (mp_q[0] ? mc_q : '0);
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, b_q};
  assign rem_nx = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_nx = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
  assign res1   = single_op(op_q, a_q, b_q);
  assign last   = (cnt_q == LAST);

`ifdef BINOP_SEQ_ALU_POW_EN
  logic [WIDTH-1:0] pw_q, pw_d, pw_nx;
  logic [CW-1:0]    bit_q, bit_d;
  logic             sq_q, sq_d;
  assign pw_nx = b_q[bit_q] ? pp_nx : pw_q;
`endif

  always_comb begin
    state_d  = state_q;
    go_d     = go_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    mc_d     = mc_q;
    mp_d     = mp_q;
    pp_d     = pp_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;
`ifdef BINOP_SEQ_ALU_POW_EN
    pw_d     = pw_q;
    bit_d    = bit_q;
    sq_d     = sq_q;
`endif
    in_ready  = (state_q == S_IDLE) && !go_q;
    out_valid = (state_q == S_DONE);
    case (state_q)
      S_IDLE: begin
        // go_q marks the dispatch cycle between acceptance and the first compute step.
        if (go_q) begin
          go_d  = 1'b0;
          cnt_d = '0;
          pp_d  = '0;
          case (op_q)
            OP_MUL: begin
              mc_d    = a_q;
              mp_d    = b_q;
              state_d = S_MUL;
            end
            OP_DIV, OP_MOD: begin
              rem_d   = '0;
              quo_d   = a_q;
              state_d = S_DIV;
            end
`ifdef BINOP_SEQ_ALU_POW_EN
            OP_POW: begin
              pw_d    = WIDTH'(1);
              mc_d    = WIDTH'(1);
              mp_d    = WIDTH'(1);
              bit_d   = LAST;
              sq_d    = 1'b1;
              state_d = S_POW;
            end
`endif
            default: begin
              result_d = res1[WIDTH-1:0];
              err_d    = res1[WIDTH];
              state_d  = S_DONE;
            end
          endcase
        end else if (in_valid) begin
          go_d = 1'b1;
          op_d = op;
          a_d  = a;
          b_d  = b;
        end
      end
      S_MUL: begin
        pp_d  = pp_nx;
        mc_d  = mc_q << 1;
        mp_d  = mp_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          result_d = pp_nx;
          err_d    = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_DIV: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          state_d = S_DONE;
          if (b_q == '0) begin
            result_d = (op_q == OP_DIV) ? '1 : a_q;
            err_d    = 1'b1;
          end else begin
            result_d = (op_q == OP_DIV) ? quo_nx : rem_nx;
            err_d    = 1'b0;
          end
        end
      end
`ifdef BINOP_SEQ_ALU_POW_EN
      // Alternates a square phase and a multiply-by-a phase per exponent bit, MSB first.
      S_POW: begin
        pp_d  = pp_nx;
        mc_d  = mc_q << 1;
        mp_d  = mp_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          cnt_d = '0;
          pp_d  = '0;
          if (sq_q) begin
            pw_d = pp_nx;
            mc_d = a_q;
            mp_d = pp_nx;
            sq_d = 1'b0;
          end else begin
            pw_d = pw_nx;
            mc_d = pw_nx;
            mp_d = pw_nx;
            sq_d = 1'b1;
            if (bit_q == '0) begin
              result_d = pw_nx;
              err_d    = 1'b0;
              state_d  = S_DONE;
            end else begin
              bit_d = bit_q - CW'(1);
            end
          end
        end
      end
`endif
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      go_q     <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mc_q     <= '0;
      mp_q     <= '0;
      pp_q     <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
`ifdef BINOP_SEQ_ALU_POW_EN
      pw_q     <= '0;
      bit_q    <= '0;
      sq_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      go_q     <= go_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mc_q     <= mc_d;
      mp_q     <= mp_d;
      pp_q     <= pp_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
`ifdef BINOP_SEQ_ALU_POW_EN
      pw_q     <= pw_d;
      bit_q    <= bit_d;
      sq_q     <= sq_d;
`endif
    end
  end

  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_binop_seq_alu.sv
// Scoreboard bench for binop_seq_alu: driver pushes model results, monitor pops on out_valid.
module tb_binop_seq_alu;
  localparam int W = 8;
  localparam int M = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, out_valid, out_ready, err;
  logic [4:0]   op;
  logic [W-1:0] a, b, result;

  always #5 clk = ~clk;

  binop_seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .err(err)
  );

  typedef struct {int res; bit e; int lat; int acc;} exp_t;
  exp_t q[$];
  exp_t mex;
  int   n_vec = 0, n_err = 0, cyc = 0, or_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Reference behaviour from the op definitions, using plain integer arithmetic.
  function automatic void model(input int o, input int x, input int y,
                                output int r, output bit e, output int lat);
    int sx;
    longint p;
    r = 0; e = 0; lat = 1;
    case (o)
      0:  r = x & y;
      1:  r = x | y;
      2:  r = x ^ y;
      3:  r = ~(x ^ y) & M;
      4:  r = (y >= W) ? 0 : ((x << y) & M);
      5:  r = (y >= W) ? 0 : (x >> y);
      6: begin
        sx = (x >= (1 << (W-1))) ? x - (1 << W) : x;
        r  = (y >= W) ? ((sx < 0) ? M : 0) : ((sx >>> y) & M);
      end
      7:  r = (x != 0 && y != 0) ? 1 : 0;
      8:  r = (x != 0 || y != 0) ? 1 : 0;
      9:  r = (x == y) ? 1 : 0;
      10: r = (x != y) ? 1 : 0;
      11: r = (x <  y) ? 1 : 0;
      12: r = (x <= y) ? 1 : 0;
      13: r = (x >= y) ? 1 : 0;
      14: r = (x >  y) ? 1 : 0;
      15: r = (x + y) & M;
      16: r = (x - y) & M;
      17: begin r = (x * y) & M; lat = W + 1; end
      18: begin lat = W + 1; if (y == 0) begin r = M; e = 1; end else r = x / y; end
      19: begin lat = W + 1; if (y == 0) begin r = x; e = 1; end else r = x % y; end
`ifdef BINOP_SEQ_ALU_POW_EN
      20: begin
        p = 1;
        for (int i = 0; i < y; i++) p = (p * x) % (M + 1);
        r = int'(p); lat = 2 * W * W + 1;
      end
`endif
      default: e = 1;
    endcase
  endfunction

  task automatic send(input int o, input int x, input int y);
    exp_t ex;
    int t;
    @(negedge clk);
    in_valid = 1'b1; op = o[4:0]; a = x[W-1:0]; b = y[W-1:0];
    t = 0;
    while (!in_ready && t < 3000) begin @(negedge clk); t++; end
    if (!in_ready) begin
      n_vec++; n_err++;
      $display("FAIL in_ready_timeout: got 0 expected 1 (op %0d)", o);
      in_valid = 1'b0;
      return;
    end
    model(o, x, y, ex.res, ex.e, ex.lat);
    ex.acc = cyc + 1;
    q.push_back(ex);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q.size() != 0 || out_valid) && t < 5000) begin @(negedge clk); t++; end
    if (t >= 5000) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
  endtask

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (or_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: checks each result once, then its stability while the consumer stalls.
  logic [W-1:0] h_res;
  logic         h_err;
  bit           held = 0;
  always @(negedge clk) begin
    if (!rst_n) held = 0;
    else if (out_valid) begin
      if (!held) begin
        if (q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_out: got result %0d expected no output", result);
        end else begin
          mex = q.pop_front();
          chk("result", result, mex.res);
          chk("err", err, mex.e);
          chk("latency", cyc - mex.acc, mex.lat);
          h_res = mex.res[W-1:0];
          h_err = mex.e;
        end
        held = 1;
      end else begin
        chk("hold_result", result, h_res);
        chk("hold_err", err, h_err);
      end
      chk("in_ready_busy", in_ready, 0);
      if (out_ready) held = 0;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int dop[] = '{15, 17, 18, 19, 18, 19, 6, 4, 20, 21, 31, 9, 14, 7, 8};
  int dx[]  = '{200, 13, 100, 100, 100, 100, 'h90, 1, 3, 5, 7, 55, 3, 0, 0};
  int dy[]  = '{100, 11, 7, 7, 0, 0, 9, 8, 5, 6, 9, 55, 4, 9, 0};

  initial begin
    int o, x, y, t;
    rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_result", result, 0);
    chk("rst_err", err, 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("rel_out_valid", out_valid, 0);
    chk("rel_in_ready", in_ready, 1);

    or_mode = 2;
    foreach (dop[i]) send(dop[i], dx[i], dy[i]);
    drain();

    or_mode = 1;
    send(17, 13, 11);
    t = 0;
    while (!out_valid && t < 100) begin @(negedge clk); t++; end
    repeat (5) @(negedge clk);
    or_mode = 2;
    drain();

    send(17, 200, 3);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_result", result, 0);
    chk("midrst_err", err, 0);
    q.delete();
    @(negedge clk) rst_n = 1'b1;
    repeat (W + 4) begin
      @(negedge clk);
      chk("no_stale", out_valid, 0);
    end

    or_mode = 0;
    for (int i = 0; i < 200; i++) begin
      o = ($urandom_range(0, 9) == 0) ? $urandom_range(21, 31) : $urandom_range(0, 20);
      x = $urandom_range(0, M);
      case ($urandom_range(0, 3))
        0:       y = 0;
        1:       y = $urandom_range(0, W + 1);
        default: y = $urandom_range(0, M);
      endcase
      send(o, x, y);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/binop_seq_alu.md
BINOP_SEQ_ALU -- requirements
Module: binop_seq_alu

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operand/opcode request valid.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 op  input  5  opcode: 0 AND, 1 OR, 2 XOR, 3 XNOR, 4 SHL, 5 SHR, 6 SSHR, 7 LAND, 8 LOR, 9 EQ, 10 NE, 11 LT, 12 LE, 13 GE, 14 GT, 15 ADD, 16 SUB, 17 MUL, 18 DIV, 19 MOD, 20 POW; 21..31 illegal.
REQ-007 a, b  input  WIDTH  unsigned operands; SSHR treats a as two's complement.
REQ-008 out_valid  output  1  result valid.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 result  output  WIDTH  operation result, truncated modulo 2^WIDTH.
REQ-011 err  output  1  qualifies result: illegal opcode or divide by zero.

Function
REQ-012 Request accepted on a rising edge with in_valid=1 and in_ready=1; a, b, op are registered at acceptance and ignored afterwards.
REQ-013 in_ready=1 only in state IDLE; no new request is accepted while computing or while a result is pending.
REQ-014 States: IDLE, MUL, DIV, POW, DONE. IDLE->DONE for single-cycle ops and illegal opcodes; IDLE->MUL/DIV/POW for ops 17/18-19/20; MUL/DIV/POW->DONE on final iteration; DONE->IDLE on an edge with out_ready=1.
REQ-015 Latency, acceptance edge = edge k: out_valid rises after edge k+1 for ops 0..16 and illegal; after k+WIDTH+1 for MUL/DIV/MOD; after k+2*WIDTH*WIDTH+1 for POW; latency is data-independent.
REQ-016 out_valid=1 exactly in DONE; result and err held stable while out_valid=1 and out_ready=0.
REQ-017 Comparison and logical ops (7..14) return 1 or 0 zero-extended to WIDTH; LAND/LOR treat a nonzero operand as true.
REQ-018 Shifts: amount b; when b>=WIDTH, SHL/SHR return 0 and SSHR returns all bits equal to a[WIDTH-1].
REQ-019 MUL: iterative shift-add, one partial product per cycle, WIDTH cycles, low WIDTH bits of the product.
REQ-020 DIV/MOD: restoring division, one quotient bit per cycle, WIDTH cycles; DIV returns quotient, MOD returns remainder.
REQ-021 b=0 for DIV: result all-ones, err=1; for MOD: result=a, err=1; latency unchanged.
REQ-022 POW: square-and-multiply over exponent bits MSB to LSB, each bit one square plus one multiply on the MUL datapath (product discarded when bit clear); 0**0=1.
REQ-023 Illegal opcode: result 0, err=1; err=0 for all other legal cases.

Reset
REQ-024 rst_n=0 forces state IDLE immediately, independent of clk: out_valid=0, result=0, err=0, in_ready=1 while rst_n=0 and after release.
REQ-025 Reset asserted mid-operation abandons the operation; no result is produced for it.

Configuration
REQ-026 Macro BINOP_SEQ_ALU_POW_EN: when defined, POW (op 20) is implemented per REQ-022; when undefined, POW state and logic are absent and op 20 is treated as illegal (result 0, err=1, latency 1).

Verification
REQ-027 WIDTH=8, op=15, a=200, b=100, out_ready=1 -> out_valid one cycle after accept, result=44, err=0.
REQ-028 op=17, a=13, b=11 -> out_valid exactly 9 cycles after accept, result=143; in_ready=0 throughout.
REQ-029 op=18 then op=19, a=100, b=7 -> results 14 and 2; repeat with b=0 -> 255/err=1 and 100/err=1.
REQ-030 op=6, a=0x90, b=9 -> result 0xFF; op=4, a=0x01, b=8 -> result 0x00.
REQ-031 With BINOP_SEQ_ALU_POW_EN: op=20, a=3, b=5 -> result 243 after 129 cycles; without it: result 0, err=1 after 1 cycle.
REQ-032 out_ready held 0 for 5 cycles after result -> result/err stable, in_ready=0; rst_n pulsed low during MUL -> out_valid=0, in_ready=1 immediately, no stale result.
